image_loader: RTL
=================

// Module: image_loader
// PURPOSE
//   Streams a 4-bit-per-pixel image into the frame-buffer RAM write port, the writer half of the
//   image store the VGA pixel path reads from. Takes a byte stream (valid/ready) from the host
//   link: one sync byte, then IMG_W*IMG_H/2 payload bytes carrying two pixels each.
//   The loader unpacks each byte into two sequential RAM writes and signals completion.
// PARAMETERS
//   IMG_W      640    image width in pixels
//   IMG_H      480    image height in pixels; IMG_W*IMG_H must be even (elaboration $error otherwise)
//   SYNC_BYTE  8'hA5  frame-start marker expected before payload
//   ADDR_W is a localparam, not a parameter: $clog2(IMG_W*IMG_H). Same addressing as the read side.
// PORTS
//   clk       in   1       system clock
//   rst_n     in   1       asynchronous active-low reset
//   start     in   1       1-cycle request to arm a load; ignored unless IDLE
//   abort     in   1       return to IDLE from any state; no further writes
//   s_data    in   8       stream byte; [7:4] = even pixel, [3:0] = odd pixel
//   s_valid   in   1       s_data valid
//   s_ready   out  1       loader accepts s_data this cycle
//   wr_en     out  1       RAM write strobe, registered
//   wr_addr   out  ADDR_W  RAM write address, registered
//   wr_data   out  4       RAM write pixel, registered
//   busy      out  1       high in any state other than IDLE
//   done      out  1       1-cycle pulse, asserted in the same cycle as the final wr_en
//   sync_err  out  1       1-cycle pulse for each non-SYNC byte discarded in WAIT_SYNC
// BEHAVIOUR
//   Reset: state=IDLE, s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, sync_err=0, ptr=0.
//   Handshake: a byte transfers on a cycle where s_valid & s_ready. s_ready is a combinational
//     decode of state only (1 in WAIT_SYNC and LOAD_HI). It never depends on s_valid.
//   FSM:
//     IDLE      : start -> WAIT_SYNC, ptr<=0.
//     WAIT_SYNC : on xfer, s_data==SYNC_BYTE -> LOAD_HI; any other byte is dropped, sync_err pulses
//                 the next cycle, and the state is unchanged.
//     LOAD_HI   : on xfer, latch s_data[3:0] into lo_hold. Next cycle: wr_en=1, wr_addr=ptr,
//                 wr_data=s_data[7:4]. ptr<=ptr+1. -> LOAD_LO.
//     LOAD_LO   : s_ready=0. Next cycle: wr_en=1, wr_addr=ptr, wr_data=lo_hold.
//                 If ptr==IMG_W*IMG_H-1 then done=1 in that same cycle, state -> IDLE, ptr<=0.
//                 Otherwise ptr<=ptr+1 and -> LOAD_HI.
//   Latency: write of the high nibble is 1 cycle after the byte transfer; the low nibble follows 1 cycle later.
//   Peak rate is 1 byte per 2 cycles. Stalls (s_valid=0) in LOAD_HI produce no writes.
//   wr_en is low on every cycle without a write. wr_addr/wr_data hold their last value when idle.
//   ptr never wraps: the final address is IMG_W*IMG_H-1, and the load ends there.
//   Bytes offered after done are not accepted (IDLE, s_ready=0).
//   abort has priority over all transitions: next state=IDLE, ptr<=0, and no wr_en in the following cycle.
//     A partly written frame is left as is.
//   start and abort in the same cycle: abort wins. start while busy: ignored.
//   An asynchronous reset mid-load clears all state. RAM contents are not touched.
// STRUCTURE
//   image_pkg: typedef enum logic [2:0] {IDLE, WAIT_SYNC, LOAD_HI, LOAD_LO} loader_state_t;
//     the pixel width constant PIX_W=4; default SYNC_BYTE.
//   Single module with no sub-module: one state register, ptr, lo_hold, and the registered write port.
//   Pairs with the dual-port frame-buffer RAM. Its read port is what the VGA pixel path consumes.
// TESTING
//   1 Reset: rst_n=0 mid-LOAD_LO -> all outputs 0 immediately (async); state IDLE after release.
//   2 Happy path at IMG_W=4, IMG_H=2: start, A5, 12, 34, 56, 78 back-to-back
//     -> writes (0,1),(1,2),(2,3),(3,4),(4,5),(5,6),(6,7),(7,8); done with the write to addr 7.
//   3 Sync hunt: bytes 00, FF, A5, 9C -> sync_err pulses twice; writes (0,9),(1,C) only.
//   4 Back-pressure: s_valid held 1 throughout -> s_ready toggles 1,0 in LOAD phase;
//     no byte is lost or duplicated; the wr_addr sequence is contiguous.
//   5 Stalls: s_valid gaps of 3 cycles between bytes -> no wr_en during the gaps; final RAM image is unchanged vs test 2.
//   6 Abort after 3 bytes -> no wr_en next cycle; busy=0; new start+sync restarts at addr 0.
//     Extra bytes after done are not accepted.

Source files
------------

// File: rtl/image_pkg.sv
// Shared types and constants for the frame-buffer image loader.
package image_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    LOAD_HI,
    LOAD_LO
  } loader_state_t;

  // Bits per pixel stored in the frame buffer
  localparam int PIX_W = 4;

  // Default frame-start marker sent by the host ahead of the payload
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/image_loader.sv
// Image loader: takes a host byte stream (sync byte + packed pixel pairs) and
// turns each payload byte into two sequential frame-buffer RAM writes.
module image_loader
  import image_pkg::*;
#(
  parameter int         IMG_W     = 640,
  parameter int         IMG_H     = 480,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  localparam int        ADDR_W    = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              sync_err
);

  localparam int                NPIX      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  // Two pixels per byte: an odd pixel count cannot be streamed
  if ((NPIX % 2) != 0) begin : g_odd_pixel_count
    $error("image_loader: IMG_W*IMG_H must be even");
  end

  loader_state_t     state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [PIX_W-1:0]  lo_hold, lo_hold_n;
  logic              wr_en_n, done_n, sync_err_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [PIX_W-1:0]  wr_data_n;
  logic              xfer;

  // Ready is a pure decode of state so the host never sees a valid->ready loop
  assign s_ready = (state == WAIT_SYNC) || (state == LOAD_HI);
  assign busy    = (state != IDLE);
  assign xfer    = s_valid & s_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode; abort overrides every other transition
  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:      if (start) state_n = WAIT_SYNC;
        WAIT_SYNC: if (xfer && (s_data == SYNC_BYTE)) state_n = LOAD_HI;
        LOAD_HI:   if (xfer) state_n = LOAD_LO;
        LOAD_LO:   state_n = (ptr == LAST_ADDR) ? IDLE : LOAD_HI;
        default:   state_n = IDLE;
      endcase
    end
  end

  // Next values for the write port, pixel pointer and held low nibble
  always_comb begin
    wr_en_n    = 1'b0;
    done_n     = 1'b0;
    sync_err_n = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    ptr_n      = ptr;
    lo_hold_n  = lo_hold;
    if (abort) begin
      ptr_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) ptr_n = '0;
        end
        WAIT_SYNC: begin
          if (xfer && (s_data != SYNC_BYTE)) sync_err_n = 1'b1;
        end
        LOAD_HI: begin
          if (xfer) begin
            wr_en_n   = 1'b1;
            wr_addr_n = ptr;
            wr_data_n = s_data[7:4];
            lo_hold_n = s_data[3:0];
            ptr_n     = ptr + ADDR_W'(1);
          end
        end
        LOAD_LO: begin
          wr_en_n   = 1'b1;
          wr_addr_n = ptr;
          wr_data_n = lo_hold;
          if (ptr == LAST_ADDR) begin
            done_n = 1'b1;
            ptr_n  = '0;
          end else begin
            ptr_n = ptr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered write port, status pulses and pixel pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      sync_err <= 1'b0;
      ptr      <= '0;
    end else begin
      wr_en    <= wr_en_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      done     <= done_n;
      sync_err <= sync_err_n;
      ptr      <= ptr_n;
    end
  end

  // Low-nibble holding register; pure data, only meaningful after a LOAD_HI transfer
  always_ff @(posedge clk) begin
    lo_hold <= lo_hold_n;
  end

endmodule
